// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A prescaler sets the dwell time per digit. The scan index walks downward
//   through the enabled digits only. Each digit can blink, and a frame strobe
//   marks every wrap of the scan.
//
// Ports
//   CLK    system clock; all state changes on the rising edge
//   RST    synchronous, active-high reset
//   EN     per-digit enable mask; a 0 bit skips and blanks that digit
//   BLINK  per-digit blink request
//   DIN    packed codes; digit i is DIN[i*DATA_W +: DATA_W]; digit 0 is rightmost
//   an     active-low anodes; at most one bit is low
//   out    code of the lit digit; 0 when nothing is lit
//   sel    current scan index
//   frame  one-cycle strobe on the tick where the scan wraps
module display_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 5,
  parameter int TICK_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_DIGITS-1:0]        EN,
  input  logic [NUM_DIGITS-1:0]        BLINK,
  input  logic [NUM_DIGITS*DATA_W-1:0] DIN,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [DATA_W-1:0]            out,
  output logic [$clog2(NUM_DIGITS)-1:0] sel,
  output logic                         frame
);

  localparam int unsigned ND     = NUM_DIGITS;
  localparam int          IDX_W  = $clog2(NUM_DIGITS);
  localparam int          CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
  blink_phase_e      phase_q, phase_d;

  logic              tick;
  logic              any_en;
  logic [IDX_W-1:0]  next_idx;
  logic              wrap;

  logic [DATA_W-1:0] digit [NUM_DIGITS];
  logic [IDX_W-1:0]  eff_idx;
  blink_phase_e      eff_phase;
  logic              lit;

  always_comb begin
    for (int unsigned i = 0; i < ND; i++) begin
      digit[i] = DIN[i*DATA_W +: DATA_W];
    end
  end

  assign tick   = (cnt_q == CNT_LAST);
  assign any_en = |EN;

  // Search idx-1, idx-2, ... (wrapping) for the first enabled digit.
  // The current digit is never a candidate. When nothing else is enabled,
  // the index stays where it is.
  always_comb begin
    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    next_idx = idx_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k < ND; k++) begin
      cand     = (32'(idx_q) + ND - k) % ND;
      cand_idx = IDX_W'(cand);
      if (!found && EN[cand_idx]) begin
        next_idx = cand_idx;
        found    = 1'b1;
      end
    end
  end

  // A wrap is any advance that does not move to a lower index. This also
  // covers staying put when a single digit is enabled.
  assign wrap = tick & any_en & (next_idx >= idx_q);

  // While reset is held, the outputs already show the post-reset state.
  assign eff_idx   = RST ? LAST_IDX : idx_q;
  assign eff_phase = RST ? PHASE_ON : phase_q;
  assign lit       = EN[eff_idx] & ~(BLINK[eff_idx] & (eff_phase == PHASE_OFF));

  always_comb begin
    an = '1;
    if (lit) begin
      an[eff_idx] = 1'b0;
    end
    out = lit ? digit[eff_idx] : '0;
  end

  assign sel   = eff_idx;
  assign frame = wrap & ~RST;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = (tick && any_en) ? next_idx : idx_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= LAST_IDX;
      fcnt_q  <= '0;
      phase_q <= PHASE_ON;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

endmodule
